// File: rtl/hmove_entry.sv
// hmove_entry: human-move entry stage feeding the tic-tac-toe FSM; tracks both boards and game end.
// Optional build macro DEBOUNCE_EN: submit must stay high DEBOUNCE_CYCLES cycles before it counts.
module hmove_entry #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] sw,
  input  logic       submit,
  input  logic [3:0] cMove,
  input  logic       cMove_valid,
  input  logic       win,
  output logic [3:0] hMove,
  output logic       hMove_valid,
  output logic       illegal,
  output logic       cpu_err,
  output logic [8:0] board_h,
  output logic [8:0] board_c,
  output logic       game_over
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_C = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t     state, state_nx;
  logic       s1, s2, go;
  logic [3:0] count, count_nx;
  logic [8:0] board_h_nx, board_c_nx;
  logic [3:0] hmove_nx;
  logic       hv_nx, ill_nx, err_nx;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= submit;
      s2 <= s1;
    end
  end

`ifdef DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CW-1:0] deb_cnt;
  logic          stable, stable_d;

  assign stable = (deb_cnt == CW'(DEBOUNCE_CYCLES));

  always_ff @(posedge clock) begin
    if (reset) begin
      deb_cnt  <= '0;
      stable_d <= 1'b0;
    end else begin
      if (!s2)          deb_cnt <= '0;
      else if (!stable) deb_cnt <= deb_cnt + CW'(1);
      stable_d <= stable;
    end
  end

  // The counter parks at its limit while held, so go is the rising edge of "stable".
  assign go = stable & ~stable_d;
`else
  logic s2_d;

  always_ff @(posedge clock) begin
    if (reset) s2_d <= 1'b0;
    else       s2_d <= s2;
  end

  assign go = s2 & ~s2_d;
`endif

  // One-hot square decode; 0 and 10..15 fall outside bits 9:1 and decode to nothing.
  logic [15:0] h_dec, c_dec;
  logic [8:0]  h_bit, c_bit, occupied;
  logic        h_ok, c_ok;

  assign h_dec    = 16'd1 << sw;
  assign c_dec    = 16'd1 << cMove;
  assign h_bit    = h_dec[9:1];
  assign c_bit    = c_dec[9:1];
  assign occupied = board_h | board_c;
  assign h_ok     = (|h_bit) && !(|(h_bit & occupied));
  assign c_ok     = (|c_bit) && !(|(c_bit & occupied));

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nx   = state;
    count_nx   = count;
    board_h_nx = board_h;
    board_c_nx = board_c;
    hmove_nx   = hMove;
    hv_nx      = 1'b0;
    ill_nx     = 1'b0;
    err_nx     = 1'b0;

    case (state)
      IDLE: begin
        if (go) begin
          if (h_ok) begin
            hmove_nx   = sw;
            hv_nx      = 1'b1;
            board_h_nx = board_h | h_bit;
            if (count != 4'd9) count_nx = count + 4'd1;
            state_nx   = WAIT_C;
          end else begin
            ill_nx = 1'b1;
          end
        end
      end
      WAIT_C: begin
        if (cMove_valid) begin
          if (c_ok) begin
            board_c_nx = board_c | c_bit;
            if (count != 4'd9) count_nx = count + 4'd1;
          end else begin
            err_nx = 1'b1;
          end
          state_nx = IDLE;
        end
      end
      DONE:    state_nx = DONE;
      default: state_nx = IDLE;
    endcase

    // End of game overrides the normal transition, after this cycle's move is recorded.
    if (win || count_nx == 4'd9) state_nx = DONE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      count       <= 4'd0;
      board_h     <= 9'd0;
      board_c     <= 9'd0;
      hMove       <= 4'd0;
      hMove_valid <= 1'b0;
      illegal     <= 1'b0;
      cpu_err     <= 1'b0;
    end else begin
      state       <= state_nx;
      count       <= count_nx;
      board_h     <= board_h_nx;
      board_c     <= board_c_nx;
      hMove       <= hmove_nx;
      hMove_valid <= hv_nx;
      illegal     <= ill_nx;
      cpu_err     <= err_nx;
    end
  end

  assign game_over = (state == DONE);

endmodule

// File: tb/tb_hmove_entry.sv
// tb_hmove_entry: directed plus randomized games for hmove_entry against a move-level game model.
// Build with DEBOUNCE_EN defined to exercise the debounced submit path.
module tb_hmove_entry;

  localparam int DEB = 16;
`ifdef DEBOUNCE_EN
  localparam int LAT = 2 + DEB + 1;
`else
  localparam int LAT = 3;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] sw;
  logic       submit;
  logic [3:0] cMove;
  logic       cMove_valid;
  logic       win;
  logic [3:0] hMove;
  logic       hMove_valid;
  logic       illegal;
  logic       cpu_err;
  logic [8:0] board_h;
  logic [8:0] board_c;
  logic       game_over;

  always #5 clock = ~clock;

  hmove_entry #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clock       (clock),
    .reset       (reset),
    .sw          (sw),
    .submit      (submit),
    .cMove       (cMove),
    .cMove_valid (cMove_valid),
    .win         (win),
    .hMove       (hMove),
    .hMove_valid (hMove_valid),
    .illegal     (illegal),
    .cpu_err     (cpu_err),
    .board_h     (board_h),
    .board_c     (board_c),
    .game_over   (game_over)
  );

  int vectors = 0;
  int errors  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Game model: who holds which square, whose turn it is, and whether play has ended.
  bit         h_occ[16];
  bit         c_occ[16];
  int         moves;
  bit         cpu_turn;
  bit         over;
  logic [3:0] last_h;

  function automatic logic [8:0] board_of(input bit cpu_side);
    logic [8:0] v;
    for (int i = 1; i <= 9; i++) v[i-1] = cpu_side ? c_occ[i] : h_occ[i];
    return v;
  endfunction

  function automatic bit free_square(input int sq);
    return (sq >= 1) && (sq <= 9) && !h_occ[sq] && !c_occ[sq];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      h_occ[i] = 1'b0;
      c_occ[i] = 1'b0;
    end
    moves = 0; cpu_turn = 1'b0; over = 1'b0; last_h = 4'd0;
  endtask

  task automatic check_strobes(input string tag, input bit hv, input bit ill, input bit err);
    check({tag, ".hMove_valid"}, 32'(hMove_valid), 32'(hv));
    check({tag, ".illegal"},     32'(illegal),     32'(ill));
    check({tag, ".cpu_err"},     32'(cpu_err),     32'(err));
  endtask

  task automatic check_all(input string tag, input bit hv, input bit ill, input bit err);
    check_strobes(tag, hv, ill, err);
    check({tag, ".hMove"},     32'(hMove),     32'(last_h));
    check({tag, ".board_h"},   32'(board_h),   32'(board_of(1'b0)));
    check({tag, ".board_c"},   32'(board_c),   32'(board_of(1'b1)));
    check({tag, ".game_over"}, 32'(game_over), 32'(over));
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; submit = 1'b0; cMove_valid = 1'b1; win = 1'b1; cMove = 4'd5; sw = 4'd5;
    repeat (2) @(negedge clock);
    model_reset();
    check_all("reset", 1'b0, 1'b0, 1'b0);
    reset = 1'b0; cMove_valid = 1'b0; win = 1'b0; cMove = 4'd0; sw = 4'd0;
  endtask

  // Press and hold the button; the one expected strobe lands LAT edges after the press.
  task automatic press(input logic [3:0] s, input int hold_in);
    bit ev_h = 1'b0;
    bit ev_i = 1'b0;
    int hold = (hold_in < LAT) ? LAT : hold_in;
    @(negedge clock);
    sw = s; submit = 1'b1;
    if (!over && !cpu_turn) begin
      if (free_square(int'(s))) begin
        ev_h = 1'b1; h_occ[s] = 1'b1; moves++; last_h = s; cpu_turn = 1'b1;
        if (moves == 9) over = 1'b1;
      end else begin
        ev_i = 1'b1;
      end
    end
    for (int i = 1; i <= hold; i++) begin
      @(negedge clock);
      if (i == LAT) check_all("press", ev_h, ev_i, 1'b0);
      else          check_strobes("hold", 1'b0, 1'b0, 1'b0);
    end
    submit = 1'b0;
    repeat (3) begin
      @(negedge clock);
      check_strobes("release", 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic cpu(input logic [3:0] cm, input bit w);
    bit ev_e = 1'b0;
    @(negedge clock);
    cMove = cm; cMove_valid = 1'b1; win = w;
    if (!over) begin
      if (cpu_turn) begin
        if (free_square(int'(cm))) begin
          c_occ[cm] = 1'b1; moves++;
        end else begin
          ev_e = 1'b1;
        end
        cpu_turn = 1'b0;
        if (moves == 9) over = 1'b1;
      end
      if (w) over = 1'b1;
    end
    @(negedge clock);
    cMove_valid = 1'b0; win = 1'b0; cMove = 4'd0;
    check_all("cpu", 1'b0, 1'b0, ev_e);
    @(negedge clock);
    check_strobes("cpu_after", 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; sw = 4'd0; submit = 1'b0; cMove = 4'd0; cMove_valid = 1'b0; win = 1'b0;
    model_reset();
    do_reset();

    // Basic move, held button, illegal submits, computer responses.
    press(4'd6, LAT + 20);
    check("board_h_6", 32'(board_h), 32'h020);
    cpu(4'd5, 1'b0);
    check("board_c_5", 32'(board_c), 32'h010);
    press(4'd0, LAT);
    press(4'd12, LAT);
    press(4'd6, LAT);
    press(4'd5, LAT);
    cpu(4'd7, 1'b0);
    press(4'd1, LAT);
    press(4'd2, LAT);
    cpu(4'd6, 1'b0);
    press(4'd2, LAT);

    // Game end: win arrives together with the third computer move.
    do_reset();
    press(4'd6, LAT); cpu(4'd1, 1'b0);
    press(4'd9, LAT); cpu(4'd2, 1'b0);
    press(4'd4, LAT); cpu(4'd3, 1'b1);
    check("win_board_c", 32'(board_c), 32'h007);
    check("win_over", 32'(game_over), 32'd1);
    press(4'd5, LAT);
    cpu(4'd7, 1'b0);
    do_reset();

`ifdef DEBOUNCE_EN
    @(negedge clock);
    sw = 4'd3; submit = 1'b1;
    repeat (10) begin
      @(negedge clock);
      check_strobes("glitch", 1'b0, 1'b0, 1'b0);
    end
    submit = 1'b0;
    repeat (LAT + 4) begin
      @(negedge clock);
      check_strobes("glitch_after", 1'b0, 1'b0, 1'b0);
    end
    press(4'd3, 30);
`endif

    // Randomized games, including submits during the computer's turn and stray wins.
    for (int g = 0; g < 40; g++) begin
      do_reset();
      for (int step = 0; step < 40 && !over; step++) begin
        if (!cpu_turn) begin
          if ($urandom_range(0, 9) == 0) cpu(4'($urandom_range(0, 15)), 1'b0);
          if ($urandom_range(0, 3) == 0) press(4'($urandom_range(0, 15)), LAT + $urandom_range(0, 4));
          else                           press(4'($urandom_range(1, 9)), LAT + $urandom_range(0, 4));
        end else begin
          if ($urandom_range(0, 5) == 0) press(4'($urandom_range(1, 9)), LAT);
          cpu(($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 9)),
              $urandom_range(0, 24) == 0);
        end
      end
      if (over) press(4'($urandom_range(1, 9)), LAT);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
